vgalcd_tgen: RTL and testbench

Parametrised display timing generator for the vgalcd controller. It produces hsync/vsync/de, a one-cycle-early pixel request, frame and line pulses, and active-area coordinates. Timing comes from per-field porch/sync/active registers. Config is shadowed and applied only at frame boundaries, sync/de polarity is programmable, and disable is graceful: the current frame finishes first. It sits between the APB register file and the pixel FIFO/output stage.

---
 rtl/vgalcd_tgen.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_vgalcd_tgen.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vgalcd_tgen.sv
// -----------------------------------------------------------------------------
// vgalcd_tgen -- display timing generator for the vgalcd controller.
//
// Produces hsync/vsync/de, a one-cycle-early pixel request, frame/line pulses
// and active-area coordinates from porch/sync/active counts. The timing config
// is shadowed and only re-sampled at frame boundaries. Disabling lets the
// current frame finish first (DRAIN).
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   en_i                  run enable (level)
//   h*_i / v*_i           active, front porch, sync width, back porch counts
//   hpol_i/vpol_i/depol_i output polarity, 1 = active-high
//   pix_vld_i             pixel FIFO holds data for the current de cycle
//   undf_clr_i            clears the sticky underflow flag
//   hsync_o/vsync_o/de_o  timing outputs, polarity applied
//   pix_req_o             high one cycle before each active pixel
//   hcnt_o/vcnt_o         active coordinates, 0 outside the active area
//   sof_o/eol_o           start-of-frame / last-active-pixel-of-line pulses
//   undf_o                sticky underflow
//   cfg_err_o             one-cycle pulse when latched config is illegal
//   busy_o                high while in RUN or DRAIN
//   dbg_state_o           current FSM state (IDLE=0, RUN=1, DRAIN=2)
//
// Pixel handshake: pix_req_o is asserted in cycle n exactly when de_o will be
// active in cycle n+1. The FIFO must then present pix_vld_i=1 during every
// cycle where de_o is active; a de cycle with pix_vld_i=0 sets undf_o.
//
// All outputs come from flops loaded with the decode of the current counter
// position, so they appear one cycle after the counters and stay mutually
// aligned. pix_req_o is loaded from the decode of the next counter position,
// which places it one cycle ahead of de_o.
// -----------------------------------------------------------------------------
module vgalcd_tgen #(
    parameter int HW = 12,
    parameter int VW = 12
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    input  logic [HW-1:0] hvsize_i,
    input  logic [HW-1:0] hfp_i,
    input  logic [HW-1:0] hsw_i,
    input  logic [HW-1:0] hbp_i,
    input  logic [VW-1:0] vvsize_i,
    input  logic [VW-1:0] vfp_i,
    input  logic [VW-1:0] vsw_i,
    input  logic [VW-1:0] vbp_i,
    input  logic          hpol_i,
    input  logic          vpol_i,
    input  logic          depol_i,
    input  logic          pix_vld_i,
    input  logic          undf_clr_i,
    output logic          hsync_o,
    output logic          vsync_o,
    output logic          de_o,
    output logic          pix_req_o,
    output logic [HW-1:0] hcnt_o,
    output logic [VW-1:0] vcnt_o,
    output logic          sof_o,
    output logic          eol_o,
    output logic          undf_o,
    output logic          cfg_err_o,
    output logic          busy_o,
    output logic [1:0]    dbg_state_o
);

    localparam int HC = HW + 2;
    localparam int VC = VW + 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [HW-1:0] hv;
        logic [HW-1:0] hfp;
        logic [HW-1:0] hsw;
        logic [HW-1:0] hbp;
        logic [VW-1:0] vv;
        logic [VW-1:0] vfp;
        logic [VW-1:0] vsw;
        logic [VW-1:0] vbp;
        logic          hpol;
        logic          vpol;
        logic          depol;
    } cfg_t;

    // Control state
    state_t        state_q,   state_d;
    logic [HC-1:0] h_q,       h_d;
    logic [VC-1:0] v_q,       v_d;
    cfg_t          cfg_q,     cfg_d;
    logic          err_hold_q, err_hold_d;

    // Output registers
    logic          hsync_q,   hsync_d;
    logic          vsync_q,   vsync_d;
    logic          de_q,      de_d;
    logic          de_act_q,  de_act_d;
    logic          pix_req_q, pix_req_d;
    logic [HW-1:0] hcnt_q,    hcnt_d;
    logic [VW-1:0] vcnt_q,    vcnt_d;
    logic          sof_q,     sof_d;
    logic          eol_q,     eol_d;
    logic          undf_q,    undf_d;
    logic          cfg_err_q, cfg_err_d;
    logic          busy_q,    busy_d;

    // Combinational helpers
    cfg_t          cfg_live;
    logic          live_ok;
    logic [HC-1:0] htot, hs_beg, hs_end;
    logic [VC-1:0] vtot, vs_beg, vs_end;
    logic          h_last, v_last, frame_last;
    logic          running_q;
    logic          hs_act, vs_act, de_geo;

    assign cfg_live = {hvsize_i, hfp_i, hsw_i, hbp_i,
                       vvsize_i, vfp_i, vsw_i, vbp_i,
                       hpol_i, vpol_i, depol_i};

    // Porches may be zero; active and sync widths may not.
    assign live_ok = (hvsize_i != '0) && (hsw_i != '0) &&
                     (vvsize_i != '0) && (vsw_i != '0);

    // Region boundaries from the shadowed config. The two extra counter bits
    // guarantee the four-field sums cannot overflow.
    assign hs_beg = HC'(cfg_q.hv) + HC'(cfg_q.hfp);
    assign hs_end = hs_beg + HC'(cfg_q.hsw);
    assign htot   = hs_end + HC'(cfg_q.hbp);
    assign vs_beg = VC'(cfg_q.vv) + VC'(cfg_q.vfp);
    assign vs_end = vs_beg + VC'(cfg_q.vsw);
    assign vtot   = vs_end + VC'(cfg_q.vbp);

    assign h_last     = (h_q == htot - HC'(1));
    assign v_last     = (v_q == vtot - VC'(1));
    assign frame_last = h_last && v_last;
    assign running_q  = (state_q != ST_IDLE);

    assign hs_act = (h_q >= hs_beg) && (h_q < hs_end);
    assign vs_act = (v_q >= vs_beg) && (v_q < vs_end);
    assign de_geo = (h_q < HC'(cfg_q.hv)) && (v_q < VC'(cfg_q.vv));

    // Next-state, counters and shadow config
    always_comb begin
        state_d    = state_q;
        h_d        = h_q;
        v_d        = v_q;
        cfg_d      = cfg_q;
        err_hold_d = err_hold_q;
        cfg_err_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                h_d = '0;
                v_d = '0;
                if (!en_i) begin
                    err_hold_d = 1'b0;
                end else if (live_ok) begin
                    state_d    = ST_RUN;
                    cfg_d      = cfg_live;
                    err_hold_d = 1'b0;
                end else begin
                    // Report a bad config once per enable attempt, not every
                    // cycle that en_i stays high.
                    cfg_err_d  = ~err_hold_q;
                    err_hold_d = 1'b1;
                end
            end
            ST_RUN, ST_DRAIN: begin
                if (frame_last) begin
                    h_d = '0;
                    v_d = '0;
                    if (!en_i) begin
                        state_d = ST_IDLE;
                    end else begin
                        cfg_d = cfg_live;
                        if (live_ok) begin
                            state_d = ST_RUN;
                        end else begin
                            state_d    = ST_IDLE;
                            cfg_err_d  = 1'b1;
                            err_hold_d = 1'b1;
                        end
                    end
                end else begin
                    state_d = en_i ? ST_RUN : ST_DRAIN;
                    if (h_last) begin
                        h_d = '0;
                        v_d = v_q + VC'(1);
                    end else begin
                        h_d = h_q + HC'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                h_d     = '0;
                v_d     = '0;
            end
        endcase
    end

    // Output decode of the current position
    always_comb begin
        hsync_d  = ~hpol_i;
        vsync_d  = ~vpol_i;
        de_d     = ~depol_i;
        de_act_d = 1'b0;
        hcnt_d   = '0;
        vcnt_d   = '0;
        sof_d    = 1'b0;
        eol_d    = 1'b0;
        busy_d   = running_q;

        if (running_q) begin
            hsync_d  = hs_act ? cfg_q.hpol  : ~cfg_q.hpol;
            vsync_d  = vs_act ? cfg_q.vpol  : ~cfg_q.vpol;
            de_d     = de_geo ? cfg_q.depol : ~cfg_q.depol;
            de_act_d = de_geo;
            sof_d    = (h_q == '0) && (v_q == '0);
            eol_d    = de_geo && (h_q == HC'(cfg_q.hv) - HC'(1));
            if (de_geo) begin
                hcnt_d = h_q[HW-1:0];
                vcnt_d = v_q[VW-1:0];
            end
        end

        // Look-ahead: de of the position the counters move to, with the config
        // that will be in force there. Leaving for IDLE suppresses it.
        pix_req_d = (state_d != ST_IDLE) &&
                    (h_d < HC'(cfg_d.hv)) && (v_d < VC'(cfg_d.vv));

        // Set dominates clear.
        undf_d = (de_act_q & ~pix_vld_i) | (undf_q & ~undf_clr_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            h_q        <= '0;
            v_q        <= '0;
            cfg_q      <= '0;
            err_hold_q <= 1'b0;
            hsync_q    <= 1'b0;
            vsync_q    <= 1'b0;
            de_q       <= 1'b0;
            de_act_q   <= 1'b0;
            pix_req_q  <= 1'b0;
            hcnt_q     <= '0;
            vcnt_q     <= '0;
            sof_q      <= 1'b0;
            eol_q      <= 1'b0;
            undf_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            h_q        <= h_d;
            v_q        <= v_d;
            cfg_q      <= cfg_d;
            err_hold_q <= err_hold_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            de_q       <= de_d;
            de_act_q   <= de_act_d;
            pix_req_q  <= pix_req_d;
            hcnt_q     <= hcnt_d;
            vcnt_q     <= vcnt_d;
            sof_q      <= sof_d;
            eol_q      <= eol_d;
            undf_q     <= undf_d;
            cfg_err_q  <= cfg_err_d;
            busy_q     <= busy_d;
        end
    end

    assign hsync_o     = hsync_q;
    assign vsync_o     = vsync_q;
    assign de_o        = de_q;
    assign pix_req_o   = pix_req_q;
    assign hcnt_o      = hcnt_q;
    assign vcnt_o      = vcnt_q;
    assign sof_o       = sof_q;
    assign eol_o       = eol_q;
    assign undf_o      = undf_q;
    assign cfg_err_o   = cfg_err_q;
    assign busy_o      = busy_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_vgalcd_tgen.sv
// -----------------------------------------------------------------------------
// tb_vgalcd_tgen -- scoreboard bench for vgalcd_tgen.
//
// The driver sets inputs just after each rising edge and pushes the output
// vector expected during that cycle into exp_q. The monitor samples the DUT on
// every falling edge and pops/compares one entry. Expected vectors come from
// the frame geometry: outputs in a cycle reflect the machine position of the
// previous cycle.
//
// Vector layout: [32] busy [31] hsync [30] vsync [29] de [28] pix_req
//                [27] sof [26] eol [25] undf [24] cfg_err [23:12] hcnt
//                [11:0] vcnt. Decode values carry an extra [33] = raw de.
// -----------------------------------------------------------------------------
module tb_vgalcd_tgen;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [11:0] hvsize, hfp, hsw, hbp;
  logic [11:0] vvsize, vfp, vsw, vbp;
  logic        hpol, vpol, depol;
  logic        pix_vld, undf_clr;
  logic        hsync, vsync, de, pix_req, sof, eol, undf, cfg_err, busy;
  logic [11:0] hcnt, vcnt;
  logic [1:0]  dbg_state;

  logic [32:0] exp_q[$];
  int          total = 0;
  int          bad = 0;

  // bench copy of the shadowed config, updated at scripted latch points
  int          s_hv, s_hfp, s_hsw, s_hbp, s_vv, s_vfp, s_vsw, s_vbp;
  logic        s_hpol, s_vpol, s_depol;
  logic [33:0] last_dec;
  logic        undf_m;

  logic [32:0] mon_e, mon_got;

  always #5 clk = ~clk;

  vgalcd_tgen #(.HW(12), .VW(12)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en),
    .hvsize_i(hvsize), .hfp_i(hfp), .hsw_i(hsw), .hbp_i(hbp),
    .vvsize_i(vvsize), .vfp_i(vfp), .vsw_i(vsw), .vbp_i(vbp),
    .hpol_i(hpol), .vpol_i(vpol), .depol_i(depol),
    .pix_vld_i(pix_vld), .undf_clr_i(undf_clr),
    .hsync_o(hsync), .vsync_o(vsync), .de_o(de), .pix_req_o(pix_req),
    .hcnt_o(hcnt), .vcnt_o(vcnt), .sof_o(sof), .eol_o(eol),
    .undf_o(undf), .cfg_err_o(cfg_err), .busy_o(busy),
    .dbg_state_o(dbg_state)
  );

  // monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e   = exp_q.pop_front();
      mon_got = {busy, hsync, vsync, de, pix_req, sof, eol, undf, cfg_err,
                 hcnt, vcnt};
      total++;
      if (mon_got !== mon_e) begin
        bad++;
        $display("FAIL outputs t=%0t got=%h exp=%h (busy,hs,vs,de,preq,sof,eol,undf,err,hcnt,vcnt)",
                 $time, mon_got, mon_e);
      end
    end
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog expired got=running exp=finished");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  function automatic logic [33:0] run_dec(input int p, input bit cont);
    int ht, vt, h, v, hn, vn;
    bit hs, vs, da, nde;
    logic [33:0] r;
    ht = s_hv + s_hfp + s_hsw + s_hbp;
    vt = s_vv + s_vfp + s_vsw + s_vbp;
    h  = p % ht;
    v  = p / ht;
    hs = (h >= s_hv + s_hfp) && (h < s_hv + s_hfp + s_hsw);
    vs = (v >= s_vv + s_vfp) && (v < s_vv + s_vfp + s_vsw);
    da = (h < s_hv) && (v < s_vv);
    if (p == ht * vt - 1) begin
      nde = cont;
    end else begin
      hn  = (p + 1) % ht;
      vn  = (p + 1) / ht;
      nde = (hn < s_hv) && (vn < s_vv);
    end
    r      = '0;
    r[33]  = da;
    r[32]  = 1'b1;
    r[31]  = hs ? s_hpol : ~s_hpol;
    r[30]  = vs ? s_vpol : ~s_vpol;
    r[29]  = da ? s_depol : ~s_depol;
    r[28]  = nde;
    r[27]  = (p == 0);
    r[26]  = da && (h == s_hv - 1);
    r[23:12] = da ? 12'(h) : 12'd0;
    r[11:0]  = da ? 12'(v) : 12'd0;
    return r;
  endfunction

  function automatic logic [33:0] idle_dec(input bit preq, input bit err);
    logic [33:0] r;
    r     = '0;
    r[31] = ~hpol;
    r[30] = ~vpol;
    r[29] = ~depol;
    r[28] = preq;
    r[24] = err;
    return r;
  endfunction

  // one clock cycle: expect last cycle's decode now, remember this cycle's
  task automatic cyc(input logic [33:0] now_dec);
    logic [32:0] o;
    o     = last_dec[32:0];
    o[25] = undf_m;
    exp_q.push_back(o);
    undf_m   = rst ? 1'b0 : ((last_dec[33] & ~pix_vld) | (undf_m & ~undf_clr));
    last_dec = now_dec;
    @(posedge clk);
    #1;
  endtask

  task automatic latch();
    s_hv = int'(hvsize); s_hfp = int'(hfp); s_hsw = int'(hsw); s_hbp = int'(hbp);
    s_vv = int'(vvsize); s_vfp = int'(vfp); s_vsw = int'(vsw); s_vbp = int'(vbp);
    s_hpol = hpol; s_vpol = vpol; s_depol = depol;
  endtask

  task automatic set_cfg_a();
    hvsize = 12'd4; hfp = 12'd1; hsw = 12'd2; hbp = 12'd1;
    vvsize = 12'd3; vfp = 12'd1; vsw = 12'd1; vbp = 12'd1;
  endtask

  // IDLE -> RUN decision cycle
  task automatic start();
    en = 1'b1;
    cyc(idle_dec(1'b1, 1'b0));
    latch();
  endtask

  // one frame; en drops/rises at the given positions, hvsize_i may change
  task automatic frame(input int drop_at, input int raise_at,
                       input int chg_at, input int chg_hv);
    int n;
    n = (s_hv + s_hfp + s_hsw + s_hbp) * (s_vv + s_vfp + s_vsw + s_vbp);
    for (int p = 0; p < n; p++) begin
      if (p == drop_at)  en = 1'b0;
      if (p == raise_at) en = 1'b1;
      if (p == chg_at)   hvsize = 12'(chg_hv);
      cyc(run_dec(p, en));
      if (p == n - 1 && en) latch();
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0;
    set_cfg_a();
    hpol = 1'b1; vpol = 1'b1; depol = 1'b1;
    pix_vld = 1'b1; undf_clr = 1'b0;
    s_hv = 0; s_hfp = 0; s_hsw = 0; s_hbp = 0;
    s_vv = 0; s_vfp = 0; s_vsw = 0; s_vbp = 0;
    s_hpol = 1'b0; s_vpol = 1'b0; s_depol = 1'b0;
    last_dec = '0;
    undf_m = 1'b0;
    @(posedge clk);
    #1;

    // reset state: everything 0
    repeat (3) cyc('0);
    rst = 1'b0;
    repeat (3) cyc(idle_dec(1'b0, 1'b0));

    // basic timing, two back-to-back frames (htotal 8, vtotal 6)
    start();
    frame(-1, -1, -1, 0);
    frame(-1, -1, -1, 0);

    // hvsize 4->6 mid-frame takes effect next frame; then back to 4
    frame(-1, -1, 10, 6);
    frame(-1, -1, 10, 4);

    // graceful disable: drop en at 20, finish frame, stay idle
    frame(20, -1, -1, 0);
    repeat (5) cyc(idle_dec(1'b0, 1'b0));

    // drop then re-raise en inside a frame: no gap
    start();
    frame(20, 30, -1, 0);
    frame(-1, -1, -1, 0);
    frame(10, -1, -1, 0);
    cyc(idle_dec(1'b0, 1'b0));

    // inverted polarity: idle levels follow live pol inputs, then a frame
    hpol = 1'b0; vpol = 1'b0; depol = 1'b0;
    repeat (3) cyc(idle_dec(1'b0, 1'b0));
    start();
    frame(-1, -1, -1, 0);
    frame(10, -1, -1, 0);
    cyc(idle_dec(1'b0, 1'b0));
    hpol = 1'b1; vpol = 1'b1; depol = 1'b1;
    repeat (2) cyc(idle_dec(1'b0, 1'b0));

    // illegal config in IDLE: single cfg_err pulse, stays idle
    hsw = 12'd0;
    en  = 1'b1;
    cyc(idle_dec(1'b0, 1'b1));
    repeat (3) cyc(idle_dec(1'b0, 1'b0));
    en = 1'b0;
    cyc(idle_dec(1'b0, 1'b0));
    hsw = 12'd2;
    repeat (2) cyc(idle_dec(1'b0, 1'b0));

    // underflow set / set-wins-over-clear / clear, then reset mid-frame
    start();
    for (int p = 0; p <= 30; p++) begin
      pix_vld  = !(p == 2 || p == 10);
      undf_clr = (p == 10 || p == 20);
      rst      = (p == 30);
      if (p < 30) cyc(run_dec(p, 1'b1));
      else        cyc('0);
    end
    rst = 1'b0; en = 1'b0; pix_vld = 1'b1; undf_clr = 1'b0;
    repeat (4) cyc(idle_dec(1'b0, 1'b0));

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
